// File: rtl/display_pkg.sv
// Shared 7-segment constants for the display scanner.
// All segment/anode signals are active-low: 0 lights, 1 turns off.
package display_pkg;
  localparam logic       SEG_ACESO     = 1'b0;
  localparam logic       SEG_DESLIGADO = 1'b1;
  localparam logic [7:0] SEG_APAGADO   = 8'hFF;
  localparam logic [6:0] SEG_BRANCO    = 7'h7F;

  // {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
endpackage

// File: rtl/decod_hex7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module decod_hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);
  always_comb begin
    segs = SEG_BRANCO;
    case (nibble)
      4'h0: segs = SEG_0;
      4'h1: segs = SEG_1;
      4'h2: segs = SEG_2;
      4'h3: segs = SEG_3;
      4'h4: segs = SEG_4;
      4'h5: segs = SEG_5;
      4'h6: segs = SEG_6;
      4'h7: segs = SEG_7;
      4'h8: segs = SEG_8;
      4'h9: segs = SEG_9;
      4'hA: segs = SEG_A;
      4'hB: segs = SEG_B;
      4'hC: segs = SEG_C;
      4'hD: segs = SEG_D;
      4'hE: segs = SEG_E;
      4'hF: segs = SEG_F;
      default: segs = SEG_BRANCO;
    endcase
  end
endmodule

// File: rtl/varredura_display.sv
// Multiplexed N-digit 7-segment scanner with ghost blanking, dp and blink.
// Leading-zero suppression is built only with VARREDURA_SUPRIME_ZEROS_EN.
module varredura_display
  import display_pkg::*;
#(
  parameter int N_DIGITOS     = 4,
  parameter int DIV_VARREDURA = 1000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         habilitar,
  input  logic                         umSegundo,
  input  logic [4*N_DIGITOS-1:0]       valores,
  input  logic [N_DIGITOS-1:0]         pontos,
  input  logic [N_DIGITOS-1:0]         piscar,
  output logic [7:0]                   displaySegments,
  output logic [N_DIGITOS-1:0]         anodos,
  output logic [$clog2(N_DIGITOS)-1:0] digitoAtual
);
  localparam int DW = $clog2(N_DIGITOS);
  localparam int PW = $clog2(DIV_VARREDURA);

  logic [PW-1:0]        presc_q, presc_d;
  logic [DW-1:0]        dig_q, dig_d;
  logic                 arm_q, arm_d;
  logic [3:0]           nib_q, nib_d;
  logic                 pt_q, pt_d, pisc_q, pisc_d;
  logic [N_DIGITOS-1:0] an_q, an_d;
  logic [7:0]           seg_q, seg_d;
  logic [6:0]           dec;
  logic                 adv, load;

  decod_hex7seg u_dec (.nibble(nib_q), .segs(dec));

`ifdef VARREDURA_SUPRIME_ZEROS_EN
  logic supr_q, supr_d, todos_zero;

  // Digit i is a leading zero when nibbles i..N-1 are all zero.
  always_comb begin
    supr_d     = supr_q;
    todos_zero = 1'b1;
    if (load) begin
      supr_d = 1'b0;
      for (int k = N_DIGITOS - 1; k >= 1; k--) begin
        if (valores[4*k +: 4] != 4'h0) todos_zero = 1'b0;
        if (dig_d == DW'(k)) supr_d = todos_zero;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) supr_q <= 1'b0;
    else       supr_q <= supr_d;
  end
`else
  logic supr_q;
  assign supr_q = 1'b0;
`endif

  always_comb begin
    presc_d = presc_q;
    dig_d   = dig_q;
    arm_d   = arm_q;
    nib_d   = nib_q;
    pt_d    = pt_q;
    pisc_d  = pisc_q;
    an_d    = '1;
    seg_d   = SEG_APAGADO;
    adv     = habilitar && !arm_q && (presc_q == PW'(DIV_VARREDURA - 1));
    // First enabled edge after reset opens digit 0's slot like an advance.
    load    = adv || (habilitar && arm_q);
    if (habilitar) begin
      arm_d   = 1'b0;
      presc_d = load ? '0 : presc_q + 1'b1;
      if (adv) dig_d = (dig_q == DW'(N_DIGITOS - 1)) ? '0 : dig_q + 1'b1;
      if (load) begin
        nib_d  = valores[4*dig_d +: 4];
        pt_d   = pontos[dig_d];
        pisc_d = piscar[dig_d];
      end else begin
        an_d  = ~(N_DIGITOS'(1) << dig_q);
        seg_d = {~pt_q, supr_q ? SEG_BRANCO : dec};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      dig_q   <= '0;
      arm_q   <= 1'b1;
      nib_q   <= '0;
      pt_q    <= 1'b0;
      pisc_q  <= 1'b0;
      an_q    <= '1;
      seg_q   <= SEG_APAGADO;
    end else begin
      presc_q <= presc_d;
      dig_q   <= dig_d;
      arm_q   <= arm_d;
      nib_q   <= nib_d;
      pt_q    <= pt_d;
      pisc_q  <= pisc_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  // Blink phase is a live level, so it gates the registered segments directly.
  assign displaySegments = (pisc_q && !umSegundo) ? SEG_APAGADO : seg_q;
  assign anodos          = an_q;
  assign digitoAtual     = dig_q;
endmodule

// File: tb/tb_varredura_display.sv
// Scoreboard bench for varredura_display (N_DIGITOS=4, DIV_VARREDURA=4).
module tb_varredura_display;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        habilitar = 1'b1;
  logic        umSegundo = 1'b1;
  logic [15:0] valores = 16'h0;
  logic [3:0]  pontos = 4'h0;
  logic [3:0]  piscar = 4'h0;
  logic [7:0]  displaySegments;
  logic [3:0]  anodos;
  logic [1:0]  digitoAtual;

  typedef struct packed {
    logic [1:0] dig;
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;
  logic [3:0] prev_an = 4'hF;

  varredura_display #(.N_DIGITOS(4), .DIV_VARREDURA(4)) dut (
    .clock(clock), .reset(reset), .habilitar(habilitar), .umSegundo(umSegundo),
    .valores(valores), .pontos(pontos), .piscar(piscar),
    .displaySegments(displaySegments), .anodos(anodos), .digitoAtual(digitoAtual)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input logic [7:0] s);
    exp_t e;
    e.dig = 2'(d);
    e.an  = ~(4'(1) << d);
    e.seg = s;
    exp_q.push_back(e);
  endtask

  // Monitor: one comparison at the first lit cycle of every slot.
  always @(negedge clock) begin
    if (!reset && mon_en && anodos != 4'hF && prev_an == 4'hF) begin
      if (exp_q.size() == 0) begin
        chk("slot_unexpected", {18'h0, digitoAtual, anodos, displaySegments}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("slot", {18'h0, digitoAtual, anodos, displaySegments}, {18'h0, e});
      end
    end
    prev_an = anodos;
  end

  task automatic do_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    #1 chk("reset_immediate", {18'h0, digitoAtual, anodos, displaySegments}, {18'h0, 2'd0, 4'hF, 8'hFF});
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clock);
    #2 chk(name, exp_q.size(), 0);
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] an_exp;
    logic       found;

    // Scan pattern with ghost gap, values 1234
    valores = 16'h1234; pontos = 4'h0; piscar = 4'h0; umSegundo = 1'b1;
    mon_en = 1'b1;
    push(0, 8'h99); push(1, 8'hB0); push(2, 8'hA4); push(3, 8'hF9);
    do_reset();
    for (int j = 0; j < 16; j++) begin
      @(posedge clock);
      #2 an_exp = (j % 4 == 0) ? 4'hF : ~(4'(1) << (j / 4));
      chk("anodos_seq", anodos, an_exp);
    end
    drain("drain_scan");

    // Blink on digit 1: scan 1 hidden phase, scan 2 visible
    piscar = 4'b0010; umSegundo = 1'b0;
    mon_en = 1'b1;
    push(0, 8'h99); push(1, 8'hFF); push(2, 8'hA4); push(3, 8'hF9);
    push(0, 8'h99); push(1, 8'hB0); push(2, 8'hA4); push(3, 8'hF9);
    do_reset();
    repeat (17) @(posedge clock);
    #2 umSegundo = 1'b1;
    repeat (6) @(posedge clock);
    #2 umSegundo = 1'b0;
    #1 chk("blink_comb_off", {anodos, displaySegments}, {4'hD, 8'hFF});
    umSegundo = 1'b1;
    #1 chk("blink_comb_on", {anodos, displaySegments}, {4'hD, 8'hB0});
    drain("drain_blink");
    piscar = 4'h0;

    // Decimal point only on digit 2
    pontos = 4'b0100;
    mon_en = 1'b1;
    push(0, 8'h99); push(1, 8'hB0); push(2, 8'h24); push(3, 8'hF9);
    do_reset();
    drain("drain_dp");
    pontos = 4'h0;

    // Reset in the middle of digit 2's slot
    mon_en = 1'b1;
    push(0, 8'h99); push(1, 8'hB0); push(2, 8'hA4);
    push(0, 8'h99); push(1, 8'hB0);
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clock);
      #2 if (digitoAtual == 2'd2 && anodos == 4'hB) found = 1'b1;
    end
    chk("reach_digit2", found, 1'b1);
    do_reset();
    drain("drain_midreset");

    // Pause for 10 cycles while digit 1 is lit
    mon_en = 1'b1;
    push(0, 8'h99); push(1, 8'hB0); push(1, 8'hB0); push(2, 8'hA4); push(3, 8'hF9);
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clock);
      #2 if (digitoAtual == 2'd1 && anodos == 4'hD) found = 1'b1;
    end
    chk("reach_digit1", found, 1'b1);
    habilitar = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #2 chk("pause_blank", {digitoAtual, anodos, displaySegments}, {2'd1, 4'hF, 8'hFF});
    end
    habilitar = 1'b1;
    @(posedge clock);
    #2 chk("resume_lit", {digitoAtual, anodos}, {2'd1, 4'hD});
    @(posedge clock);
    #2 chk("resume_held", digitoAtual, 2'd1);
    @(posedge clock);
    #2 chk("resume_adv", {digitoAtual, anodos}, {2'd2, 4'hF});
    drain("drain_pause");

    // Leading zeros
    valores = 16'h0050;
    mon_en = 1'b1;
`ifdef VARREDURA_SUPRIME_ZEROS_EN
    push(0, 8'hC0); push(1, 8'h92); push(2, 8'hFF); push(3, 8'hFF);
`else
    push(0, 8'hC0); push(1, 8'h92); push(2, 8'hC0); push(3, 8'hC0);
`endif
    do_reset();
    drain("drain_zeros_0050");

    valores = 16'h0000;
    mon_en = 1'b1;
`ifdef VARREDURA_SUPRIME_ZEROS_EN
    push(0, 8'hC0); push(1, 8'hFF); push(2, 8'hFF); push(3, 8'hFF);
`else
    push(0, 8'hC0); push(1, 8'hC0); push(2, 8'hC0); push(3, 8'hC0);
`endif
    do_reset();
    drain("drain_zeros_0000");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
